traffic_sensor_conditioner: RTL
===============================

Name: traffic_sensor_conditioner

Overview:
Upstream input stage for Traffic_Light_Controller. It turns the two raw vehicle-loop detector lines (street A, street B) into the clean presence signals Ta and Tb that the controller consumes. Each channel is synchronised, debounced on assertion, and given gap tolerance on deassertion, so the controller never sees glitches or single-cycle dropouts.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive high samples needed to assert T (legal range 2 to 255)
HOLD_CYCLES, 8, consecutive low samples needed to deassert T (legal range 2 to 255)
STUCK_CYCLES, 64, high samples in PRESENT before a stuck fault (used only with the optional feature; legal range 2 to 65535)

Ports:
clk  input  1  single system clock, rising edge
rst  input  1  synchronous, active-high reset
raw_a  input  1  raw detector, street A; asynchronous to clk
raw_b  input  1  raw detector, street B; asynchronous to clk
Ta  output  1  conditioned presence for street A; drives controller Ta
Tb  output  1  conditioned presence for street B; drives controller Tb
fault_a  output  1  sticky stuck-sensor flag, street A
fault_b  output  1  sticky stuck-sensor flag, street B

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst). Sampled only on the rising edge of clk. rst dominates every other condition.
- Reset values: sync flops 0, FSMs in IDLE, counters 0, Ta=Tb=0, fault_a=fault_b=0.
- Channel A and channel B are identical and fully independent. Below, s is the 2-flop synchronised raw input, cnt is an 8-bit counter, and T is Ta or Tb.
- T is a registered output decoded from state: T=1 in PRESENT and HOLD, T=0 in IDLE and QUAL.
- IDLE:
  - s=1 -> QUAL, cnt<=1.
  - Otherwise stay.
- QUAL:
  - s=0 -> IDLE, cnt<=0.
  - s=1 and cnt==DEBOUNCE_CYCLES-1 -> PRESENT.
  - Otherwise cnt<=cnt+1.
- PRESENT:
  - s=0 -> HOLD, cnt<=1.
  - Otherwise stay.
- HOLD:
  - s=1 -> PRESENT (T stays 1, no dropout).
  - s=0 and cnt==HOLD_CYCLES-1 -> IDLE.
  - Otherwise cnt<=cnt+1.
- Latency:
  - T rises on the (DEBOUNCE_CYCLES+2)th rising edge after raw goes high: 6 edges at the default.
  - T falls on the (HOLD_CYCLES+2)th rising edge after raw goes low: 10 edges at the default.
- Glitch rejection:
  - A raw high pulse shorter than DEBOUNCE_CYCLES clock periods never asserts T.
  - A raw low gap shorter than HOLD_CYCLES clock periods never deasserts T.
- Simultaneous rises on raw_a and raw_b give Ta and Tb on the same edge. No arbitration between channels.
- rst asserted mid-QUAL or mid-HOLD: T=0 and state IDLE after that edge. The sync flops are also cleared, so requalification starts from scratch.
- Counters never wrap: the parameter ranges guarantee the compare value is reached before 255.

Optional Feature:
Macro SENSOR_STUCK_DETECT_EN.
- Defined:
  - Each channel has a 16-bit stuck counter. It clears on entry to PRESENT and increments on each edge where state==PRESENT and s=1.
  - The edge on which it reaches STUCK_CYCLES sets fault_x=1.
  - fault_x is sticky until rst. While fault_x=1, T is forced to 1 regardless of state; the controller fails safe by treating the street as demanding.
  - The stuck counter saturates at STUCK_CYCLES.
- Not defined: fault_a and fault_b are tied to constant 0, no stuck counters are instantiated, and T comes purely from the FSM.

Test Plan:
1. Reset: rst=1 for 2 cycles with raw_a=raw_b=1 -> Ta=Tb=0 throughout. After rst drops, with raw held high, Ta and Tb both rise on the 6th edge after the last rst=1 edge.
2. Glitch: raw_a high 3 cycles then low -> Ta stays 0 and the channel returns to IDLE; raw_a high 4 cycles -> Ta rises on edge 6 after the rise.
3. Gap tolerance: with Ta=1, raw_a low 5 cycles then high -> Ta stays 1 continuously. Then raw_a low for 12 cycles -> Ta falls exactly 10 edges after the raw fall.
4. Independence: raw_b toggles 1-cycle pulses while raw_a follows scenario 3 -> Tb stays 0 and Ta is unaffected. Rise raw_a and raw_b on the same cycle -> Ta and Tb rise on the same edge.
5. Reset mid-operation: assert rst for 1 cycle while channel A is in HOLD (Ta=1) -> Ta=0 the next edge. With raw_a=1 afterward, Ta needs the full 6 edges to re-assert.
6. With SENSOR_STUCK_DETECT_EN: raw_a held high 80 cycles -> fault_a=1 on the 64th edge after Ta rises. Then drop raw_a for 20 cycles -> Ta and fault_a stay 1 until rst. Without the macro, the same stimulus gives fault_a=0 and Ta falls 10 edges after raw falls.

Source files
------------

// File: rtl/traffic_sensor_conditioner.sv
// traffic_sensor_conditioner
// Input stage for the traffic light controller. It turns two raw vehicle-loop
// detector lines into the clean presence signals Ta/Tb. Each channel is
// synchronised through two flops. It is debounced on assertion (DEBOUNCE_CYCLES
// consecutive highs) and gap-tolerant on deassertion (HOLD_CYCLES consecutive
// lows).
// Optional build macro SENSOR_STUCK_DETECT_EN: this adds a per-channel stuck
// detector. When a channel stays high for STUCK_CYCLES samples in PRESENT, its
// sticky fault flag is set and its presence output is forced high until reset.
// If the macro is undefined, the fault outputs are constant 0.

module traffic_sensor_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 8,
    parameter int STUCK_CYCLES    = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_a,
    input  logic raw_b,
    output logic Ta,
    output logic Tb,
    output logic fault_a,
    output logic fault_b
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_QUAL    = 2'd1;
    localparam logic [1:0] ST_PRESENT = 2'd2;
    localparam logic [1:0] ST_HOLD    = 2'd3;

    // The last count value before the qualifying sample closes each window.
    localparam logic [7:0] DEB_LAST_C  = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0] HOLD_LAST_C = 8'(HOLD_CYCLES - 1);

    logic [1:0] raw_s;
    logic [1:0] t_out_s;
    logic [1:0] fault_out_s;

    assign raw_s   = {raw_b, raw_a};
    assign Ta      = t_out_s[0];
    assign Tb      = t_out_s[1];
    assign fault_a = fault_out_s[0];
    assign fault_b = fault_out_s[1];

    // Two identical, fully independent channels: index 0 is street A, index 1 is street B.
    for (genvar ch = 0; ch < 2; ch++) begin : g_ch
        logic       sync1_r;
        logic       sync2_r;
        logic [1:0] state_r;
        logic [1:0] state_s;
        logic [7:0] cnt_r;
        logic [7:0] cnt_s;
        logic       fsm_t_s;
        logic       t_s;
        logic       t_r;

        // Two-flop synchroniser for the asynchronous detector line.
        always_ff @(posedge clk) begin
            if (rst) begin
                sync1_r <= 1'b0;
                sync2_r <= 1'b0;
            end else begin
                sync1_r <= raw_s[ch];
                sync2_r <= sync1_r;
            end
        end

        // Next-state and counter logic for the debounce/hold FSM.
        always_comb begin
            state_s = state_r;
            cnt_s   = cnt_r;
            case (state_r)
                ST_IDLE: begin
                    if (sync2_r) begin
                        state_s = ST_QUAL;
                        cnt_s   = 8'd1;
                    end else begin
                        state_s = ST_IDLE;
                        cnt_s   = cnt_r;
                    end
                end
                ST_QUAL: begin
                    if (!sync2_r) begin
                        state_s = ST_IDLE;
                        cnt_s   = 8'd0;
                    end else if (cnt_r == DEB_LAST_C) begin
                        state_s = ST_PRESENT;
                        cnt_s   = cnt_r;
                    end else begin
                        state_s = ST_QUAL;
                        cnt_s   = cnt_r + 8'd1;
                    end
                end
                ST_PRESENT: begin
                    if (!sync2_r) begin
                        state_s = ST_HOLD;
                        cnt_s   = 8'd1;
                    end else begin
                        state_s = ST_PRESENT;
                        cnt_s   = cnt_r;
                    end
                end
                ST_HOLD: begin
                    if (sync2_r) begin
                        // The vehicle is back inside the gap window, so there is no dropout.
                        state_s = ST_PRESENT;
                        cnt_s   = cnt_r;
                    end else if (cnt_r == HOLD_LAST_C) begin
                        state_s = ST_IDLE;
                        cnt_s   = cnt_r;
                    end else begin
                        state_s = ST_HOLD;
                        cnt_s   = cnt_r + 8'd1;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    cnt_s   = 8'd0;
                end
            endcase
        end

        // Presence is decoded from the next state, so T changes on the same edge as the FSM.
        always_comb begin
            if ((state_s == ST_PRESENT) || (state_s == ST_HOLD)) begin
                fsm_t_s = 1'b1;
            end else begin
                fsm_t_s = 1'b0;
            end
        end

`ifdef SENSOR_STUCK_DETECT_EN
        localparam logic [15:0] STUCK_LIMIT_C = 16'(STUCK_CYCLES);

        logic [15:0] stuck_r;
        logic [15:0] stuck_s;
        logic        fault_r;
        logic        fault_s;

        // Stuck counter: it restarts on each entry to PRESENT, counts high samples while
        // PRESENT, and saturates at the limit. The fault flag is sticky.
        always_comb begin
            stuck_s = stuck_r;
            fault_s = fault_r;
            if ((state_s == ST_PRESENT) && (state_r != ST_PRESENT)) begin
                stuck_s = 16'd0;
            end else if ((state_r == ST_PRESENT) && sync2_r && (stuck_r < STUCK_LIMIT_C)) begin
                stuck_s = stuck_r + 16'd1;
            end else begin
                stuck_s = stuck_r;
            end
            if (stuck_s == STUCK_LIMIT_C) begin
                fault_s = 1'b1;
            end else begin
                fault_s = fault_r;
            end
            // A faulted sensor fails safe by reporting permanent demand.
            t_s = fsm_t_s | fault_s;
        end

        // Stuck counter and sticky fault registers.
        always_ff @(posedge clk) begin
            if (rst) begin
                stuck_r <= 16'd0;
                fault_r <= 1'b0;
            end else begin
                stuck_r <= stuck_s;
                fault_r <= fault_s;
            end
        end

        assign fault_out_s[ch] = fault_r;
`else
        // Without stuck detection, presence comes purely from the FSM.
        always_comb begin
            t_s = fsm_t_s;
        end

        assign fault_out_s[ch] = 1'b0;
`endif

        // FSM state, counter and registered presence output.
        always_ff @(posedge clk) begin
            if (rst) begin
                state_r <= ST_IDLE;
                cnt_r   <= 8'd0;
                t_r     <= 1'b0;
            end else begin
                state_r <= state_s;
                cnt_r   <= cnt_s;
                t_r     <= t_s;
            end
        end

        assign t_out_s[ch] = t_r;
    end

`ifndef SENSOR_STUCK_DETECT_EN
    // The stuck threshold has no role when stuck detection is compiled out.
    logic unused_cfg_s;
    assign unused_cfg_s = ^(16'(STUCK_CYCLES));
`endif

endmodule
